// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end that shares one external combinational
// barrel shifter between two requesters and returns results over valid/ready.
module shift_arbiter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [WIDTH+SHW+1:0]   req0_cmd,
  input  logic [WIDTH+SHW+1:0]   req1_cmd,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [WIDTH-1:0]       sh_din,
  output logic [SHW-1:0]         sh_shamt,
  output logic                   sh_lr,
  output logic                   sh_al,
  input  logic [WIDTH-1:0]       sh_dout,
  output logic                   busy
);

  localparam int CW = WIDTH + SHW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, next_state;
  logic          last_grant;
  logic          gsel;
  logic          grant;
  logic          accept;
  logic [CW-1:0] sel_cmd;

  // On contention the requester not served last wins; otherwise the lone valid one.
  assign grant   = req_valid[1] & (~req_valid[0] | ~last_grant);
  assign sel_cmd = grant ? req1_cmd : req0_cmd;
  assign busy    = (state != IDLE);

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    rsp_valid  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept     = 1'b1;
          req_ready  = grant ? 2'b10 : 2'b01;
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = RESP;
      RESP: begin
        rsp_valid = gsel ? 2'b10 : 2'b01;
        if (rsp_ready[gsel]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Shifter inputs change only on accept, so they sit still through ISSUE and RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      gsel       <= 1'b0;
      sh_din     <= '0;
      sh_shamt   <= '0;
      sh_lr      <= 1'b0;
      sh_al      <= 1'b0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        gsel       <= grant;
        sh_al      <= sel_cmd[CW-1];
        sh_lr      <= sel_cmd[CW-2];
        sh_shamt   <= sel_cmd[WIDTH+SHW-1:WIDTH];
        sh_din     <= sel_cmd[WIDTH-1:0];
      end
      if (state == ISSUE) rsp_data <= sh_dout;
    end
  end

endmodule
